// File: rtl/sram_like_arbiter_pkg.sv
// Shared owner codes, SRAM-like size encodings and request-field types for sram_like_arbiter.
// Round-robin arbitration is selected by defining SRAM_ARB_RR_EN.
package sram_like_arbiter_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Everything a master must hold stable until its address is accepted.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/arb_owner_fifo.sv
// One-bit-wide owner FIFO: remembers which master issued each accepted address so that
// in-order data returns can be steered back to it.
module arb_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       din,
  output logic                       head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-like arbiter with address lock and in-order return routing.
// Define SRAM_ARB_RR_EN for round-robin contention; default is fixed data-over-inst priority.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addrok,
  output logic        inst_dataok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addrok,
  output logic        data_dataok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addrok,
  input  logic        mem_dataok,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH+1);

  lock_state_e   lock_state_q;
  logic          lock_owner_q;
`ifdef SRAM_ARB_RR_EN
  logic          last_owner_q;
`endif

  mem_req_t      inst_fields;
  mem_req_t      data_fields;
  mem_req_t      grant_fields;
  logic          grant_owner;
  logic          grant_req;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  assign inst_fields = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                         wstrb: inst_wstrb, wdata: inst_wdata};
  assign data_fields = '{wr: data_wr, size: data_size, addr: data_addr,
                         wstrb: data_wstrb, wdata: data_wdata};

  // A locked grant ignores newcomers; otherwise a lone requester wins and contention is resolved by policy.
  always_comb begin
    grant_owner = OWNER_DATA;
    if (lock_state_q == ARB_LOCKED) begin
      grant_owner = lock_owner_q;
    end else if (inst_req && !data_req) begin
      grant_owner = OWNER_INST;
    end else if (data_req && !inst_req) begin
      grant_owner = OWNER_DATA;
    end else if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
      grant_owner = ~last_owner_q;
`else
      grant_owner = OWNER_DATA;
`endif
    end
  end

  assign grant_req    = (grant_owner == OWNER_DATA) ? data_req : inst_req;
  assign grant_fields = (grant_owner == OWNER_DATA) ? data_fields : inst_fields;

  // Full depends only on registered occupancy, keeping mem_addrok out of the mem_req cone.
  assign mem_req   = grant_req && !fifo_full;
  assign mem_wr    = grant_fields.wr;
  assign mem_size  = grant_fields.size;
  assign mem_addr  = grant_fields.addr;
  assign mem_wstrb = grant_fields.wstrb;
  assign mem_wdata = grant_fields.wdata;

  assign inst_addrok = mem_req && mem_addrok && (grant_owner == OWNER_INST);
  assign data_addrok = mem_req && mem_addrok && (grant_owner == OWNER_DATA);

  assign fifo_push = mem_req && mem_addrok;
  assign fifo_pop  = mem_dataok && !fifo_empty;

  assign inst_dataok = mem_dataok && (fifo_count != '0) && (fifo_head == OWNER_INST);
  assign data_dataok = mem_dataok && (fifo_count != '0) && (fifo_head == OWNER_DATA);
  assign inst_rdata  = mem_rdata;
  assign data_rdata  = mem_rdata;

  // Lock is held across full; it only releases once the slave accepts the locked address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_state_q <= ARB_FREE;
      lock_owner_q <= OWNER_INST;
`ifdef SRAM_ARB_RR_EN
      last_owner_q <= OWNER_INST;
`endif
    end else begin
      if (lock_state_q == ARB_FREE) begin
        if (mem_req && !mem_addrok) begin
          lock_state_q <= ARB_LOCKED;
          lock_owner_q <= grant_owner;
        end
      end else begin
        if (mem_req && mem_addrok) begin
          lock_state_q <= ARB_FREE;
        end
      end
`ifdef SRAM_ARB_RR_EN
      if (fifo_push) begin
        last_owner_q <= grant_owner;
      end
`endif
    end
  end

  arb_owner_fifo #(
    .DEPTH (DEPTH)
  ) u_owner_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (grant_owner),
    .head   (fifo_head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule
